xmax_sub_buf: RTL and testbench
===============================

# xmax_sub_buf

Parametrised buffer for the softmax front end. It captures a vector of signed logits, tracks the running maximum, and emits the one-hot match vector of each logit for the CAM. It then replays the buffered vector as saturated `xi - xmax` differences over a valid/ready handshake, ready for exponent lookup. It sits between the STAR data fetch and the CAM/LUT stage. It supports any vector length from 1 to DEPTH, and the first element of each vector seeds the maximum.

## Interface
- `DW`, 8: logit and difference width, two's complement.
- `DEPTH`, 16: buffer entries; maximum vector length.
- `MVW`, 64: one-hot match-vector width.
- `OFFSET`, 20: bias added to `xi` to form the match-vector bit index.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_xi` is valid.
- `in_xi`  in  DW  signed logit.
- `in_last`  in  1  marks the final element of the vector; qualified by `in_valid`.
- `in_ready`  out  1  block accepts input (LOAD state).
- `xi_mv`  out  MVW  registered one-hot of `in_xi + OFFSET`.
- `xi_mv_valid`  out  1  `xi_mv` is valid for one cycle.
- `mv_oor`  out  1  bias index falls outside [0, MVW-1]; same cycle as `xi_mv_valid`.
- `xmax`  out  DW  signed maximum of the current vector.
- `xmax_valid`  out  1  `xmax` is final; high throughout DRAIN.
- `sub_valid`  out  1  `sub_xi` is valid.
- `sub_xi`  out  DW  signed, saturated `buf[i] - xmax`.
- `sub_last`  out  1  `sub_xi` is the last element of the vector.
- `sub_ready`  in  1  consumer accepts `sub_xi`.
- `trunc_err`  out  1  one-cycle pulse: DEPTH elements arrived without `in_last`.

## Operation
- The FSM has two states, LOAD and DRAIN.
- Reset values:
  - state = LOAD; write pointer, read pointer and count = 0.
  - All outputs are 0, except `in_ready` = 1 once out of reset.
- LOAD:
  - `in_ready` = 1. An accept (`in_valid && in_ready`) writes `buf[wr_ptr]` and increments `wr_ptr`.
  - The first accept of a vector sets `xmax = in_xi`. Each later accept sets `xmax = max(xmax, in_xi)` using a signed compare.
  - Every accept produces `xi_mv` and `xi_mv_valid` on the next cycle. `idx = in_xi + OFFSET` is computed in DW+2 signed bits.
    - If 0 ≤ idx < MVW: `xi_mv = 1 << idx`, `mv_oor` = 0.
    - Otherwise: `xi_mv` = 0, `mv_oor` = 1.
- LOAD to DRAIN:
  - An accept with `in_last` = 1 latches `count = wr_ptr + 1`.
  - An accept at `wr_ptr == DEPTH-1` without `in_last` also latches `count = DEPTH` and pulses `trunc_err`.
- DRAIN:
  - `in_ready` = 0 and `xmax_valid` = 1.
  - The output register holds `buf[rd_ptr] - xmax`, computed in DW+1 bits and clamped to -2^(DW-1). The result is never positive.
  - A handshake (`sub_valid && sub_ready`) advances `rd_ptr` and loads the next element in the same edge, so there are no bubbles.
  - `sub_last` = 1 when `rd_ptr == count-1`.
- DRAIN to LOAD:
  - Triggered by the handshake on `sub_last`.
  - `wr_ptr`, `rd_ptr` and count reset to 0; `xmax_valid` drops; `sub_valid` drops.
  - `xmax` holds its value until the next first accept reseeds it.
- `in_last` without `in_valid` is ignored.
- `sub_ready` is ignored while `sub_valid` = 0.

## Timing
- Match vector: an accept at edge k gives `xi_mv_valid` high in cycle k+1 only.
- Vector close: the closing accept lands at edge k and the state becomes DRAIN at that edge. Then:
  - `sub_valid` rises at edge k+1 with element 0.
  - `xmax` already includes the last element.
- Drain rate: with `sub_ready` held at 1, one difference per cycle. A vector of N elements drains in N cycles after the first `sub_valid`.
- Stall: while `sub_valid` = 1 and `sub_ready` = 0, `sub_xi` and `sub_last` hold stable.
- Turnaround: after the final handshake at edge m, `in_ready` = 1 in cycle m+1.
  - Minimum per-vector period is 2N+1 cycles.
- `trunc_err` is high in the cycle after the DEPTH-th accept.
- Reset: `rst_n` low at any time clears all state asynchronously.
  - An in-flight vector is discarded and `sub_valid` drops immediately.

## Test plan
- Basic vector: DW=8 and OFFSET=20. Load {3, -5, 7, 0} with `in_last` on 0, and hold `sub_ready` = 1.
  - Required: `xi_mv` bit indices 23, 15, 27, 20.
  - Required: `xmax` = 7, then `sub_xi` = -4, -12, 0, -7, with `sub_last` on -7.
- All-negative vector: load {-3, -9, -1}.
  - Required: `xmax` = -1, not 0; `sub_xi` = -2, -8, 0.
- Saturation and out-of-range: load {100, -100}.
  - Required: `mv_oor` = 1 for 100 (index 120) and for -100 (index -80).
  - Required: `sub_xi` = 0, then -128 (clamped from -200).
- Truncation: DEPTH=16. Send 17 elements with no `in_last`.
  - Required: `trunc_err` pulses after the 16th accept and `in_ready` = 0 on the 17th.
  - Required: 16 differences drain, with `sub_last` on the 16th.
- Backpressure: during drain, toggle `sub_ready` 1,0,0,1.
  - Required: `sub_xi` stable through the stall and no element dropped or duplicated.
  - Required: `in_ready` returns exactly 1 cycle after the final handshake.
- Reset mid-drain: pull `rst_n` low after 2 of 4 outputs.
  - Required: all outputs 0 immediately.
  - Required: a new vector {5} then gives `xmax` = 5 and `sub_xi` = 0.

Source files
------------

// File: rtl/xmax_sub_buf.sv
// xmax_sub_buf: softmax front-end buffer.
// Captures a vector of signed logits and tracks the running maximum.
// Emits a registered one-hot CAM match vector for every accepted logit.
// Then replays the vector as saturated (xi - xmax) differences over a
// valid/ready handshake.
module xmax_sub_buf #(
    parameter int DW     = 8,
    parameter int DEPTH  = 16,
    parameter int MVW    = 64,
    parameter int OFFSET = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_xi,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [MVW-1:0]       xi_mv,
    output logic                 xi_mv_valid,
    output logic                 mv_oor,
    output logic signed [DW-1:0] xmax,
    output logic                 xmax_valid,
    output logic                 sub_valid,
    output logic signed [DW-1:0] sub_xi,
    output logic                 sub_last,
    input  logic                 sub_ready,
    output logic                 trunc_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int MI = (MVW > 1) ? $clog2(MVW) : 1;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        rd_nxt;
    logic [CW-1:0]        count;
    logic signed [DW-1:0] mem [DEPTH];

    logic                 accept;
    logic                 at_end;
    logic                 close;
    logic                 hs;
    logic                 rd_last;
    logic                 nxt_last;
    logic signed [DW+1:0] idx;
    logic signed [31:0]   idx32;
    logic                 oor_d;
    logic [MVW-1:0]       mv_d;

    // Difference xi - xmax in DW+1 bits, clamped back into DW bits.
    function automatic logic signed [DW-1:0] sat_diff(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
        logic signed [DW:0] d;
        d = (DW+1)'(a) - (DW+1)'(b);
        if (d[DW] != d[DW-1])
            sat_diff = d[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            sat_diff = d[DW-1:0];
    endfunction

    // Handshake decode, one-hot index and next-state logic.
    always_comb begin
        state_d  = state_q;
        in_ready = rst_n && (state_q == LOAD);
        accept   = in_valid && in_ready;
        at_end   = (wr_ptr == PW'(DEPTH - 1));
        close    = accept && (in_last || at_end);
        hs       = sub_valid && sub_ready;
        rd_nxt   = rd_ptr + PW'(1);
        rd_last  = (CW'(rd_ptr) == count - CW'(1));
        nxt_last = (CW'(rd_nxt) == count - CW'(1));

        // Bias in DW+2 bits so the sum can never wrap.
        idx   = {{2{in_xi[DW-1]}}, in_xi} + (DW+2)'(OFFSET);
        idx32 = 32'(idx);
        oor_d = (idx32 < 0) || (idx32 >= MVW);
        mv_d  = '0;
        if (!oor_d)
            mv_d[idx32[MI-1:0]] = 1'b1;

        case (state_q)
            LOAD:    if (close) state_d = DRAIN;
            DRAIN:   if (hs && sub_last) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    assign xmax_valid = (state_q == DRAIN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    // Buffer storage; contents are only read after being written in LOAD.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= in_xi;
    end

    // Load side: write pointer, running max, match vector, length latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            count       <= '0;
            xmax        <= '0;
            xi_mv       <= '0;
            xi_mv_valid <= 1'b0;
            mv_oor      <= 1'b0;
            trunc_err   <= 1'b0;
        end else begin
            xi_mv_valid <= accept;
            xi_mv       <= accept ? mv_d : '0;
            mv_oor      <= accept && oor_d;
            trunc_err   <= accept && at_end && !in_last;
            if (accept) begin
                // The first element of a vector seeds the maximum.
                if (wr_ptr == '0 || in_xi > xmax)
                    xmax <= in_xi;
                wr_ptr <= close ? '0 : wr_ptr + PW'(1);
            end
            if (close)
                count <= CW'(wr_ptr) + CW'(1);
            else if (hs && sub_last)
                count <= '0;
        end
    end

    // Drain side: bubble-free replay of saturated differences.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            sub_valid <= 1'b0;
            sub_last  <= 1'b0;
            sub_xi    <= '0;
        end else if (state_q == DRAIN) begin
            if (!sub_valid) begin
                sub_valid <= 1'b1;
                sub_xi    <= sat_diff(mem[rd_ptr], xmax);
                sub_last  <= rd_last;
            end else if (sub_ready) begin
                if (sub_last) begin
                    rd_ptr    <= '0;
                    sub_valid <= 1'b0;
                    sub_last  <= 1'b0;
                    sub_xi    <= '0;
                end else begin
                    rd_ptr   <= rd_nxt;
                    sub_xi   <= sat_diff(mem[rd_nxt], xmax);
                    sub_last <= nxt_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_xmax_sub_buf.sv
// Testbench for xmax_sub_buf: directed vectors plus randomized vectors,
// checked against a queue/array reference model of the buffer behaviour.
module tb_xmax_sub_buf;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int MVW    = 64;
    localparam int OFFSET = 20;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic signed [DW-1:0] in_xi;
    logic                 in_last;
    logic                 in_ready;
    logic [MVW-1:0]       xi_mv;
    logic                 xi_mv_valid;
    logic                 mv_oor;
    logic signed [DW-1:0] xmax;
    logic                 xmax_valid;
    logic                 sub_valid;
    logic signed [DW-1:0] sub_xi;
    logic                 sub_last;
    logic                 sub_ready;
    logic                 trunc_err;

    int checks;
    int failures;

    logic signed [DW-1:0] vec [DEPTH+1];
    logic signed [DW-1:0] exp_sub [DEPTH];
    logic signed [DW-1:0] exp_max;

    xmax_sub_buf #(.DW(DW), .DEPTH(DEPTH), .MVW(MVW), .OFFSET(OFFSET)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_xi      (in_xi),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .xi_mv      (xi_mv),
        .xi_mv_valid(xi_mv_valid),
        .mv_oor     (mv_oor),
        .xmax       (xmax),
        .xmax_valid (xmax_valid),
        .sub_valid  (sub_valid),
        .sub_xi     (sub_xi),
        .sub_last   (sub_last),
        .sub_ready  (sub_ready),
        .trunc_err  (trunc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the logit values.
    function automatic bit m_oor(input int x);
        return (x + OFFSET < 0) || (x + OFFSET >= MVW);
    endfunction

    function automatic logic [63:0] m_mv(input int x);
        if (m_oor(x))
            return 64'd0;
        return 64'd1 << (x + OFFSET);
    endfunction

    function automatic logic signed [DW-1:0] m_sub(input int x, input int m);
        int d;
        d = x - m;
        if (d < -128) d = -128;
        return DW'(d);
    endfunction

    task automatic prep(input int n);
        int mx;
        mx = vec[0];
        for (int i = 1; i < n; i++)
            if (int'(vec[i]) > mx) mx = vec[i];
        exp_max = DW'(mx);
        for (int i = 0; i < n; i++)
            exp_sub[i] = m_sub(vec[i], mx);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 0);
        chk({tag, "_xi_mv"}, xi_mv, 0);
        chk({tag, "_mv_valid"}, 64'(xi_mv_valid), 0);
        chk({tag, "_mv_oor"}, 64'(mv_oor), 0);
        chk({tag, "_xmax"}, xmax, 0);
        chk({tag, "_xmax_valid"}, 64'(xmax_valid), 0);
        chk({tag, "_sub_valid"}, 64'(sub_valid), 0);
        chk({tag, "_sub_xi"}, sub_xi, 0);
        chk({tag, "_sub_last"}, 64'(sub_last), 0);
        chk({tag, "_trunc_err"}, 64'(trunc_err), 0);
    endtask

    // Present n elements; caller is positioned #1 after a clock edge.
    task automatic load_vec(input int n, input bit trunc_mode, input bit gaps);
        prep(n);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    in_valid = 1'b0;
                    in_last  = $urandom_range(0, 1);
                    @(posedge clk); #1;
                    chk("idle_mv_valid", 64'(xi_mv_valid), 0);
                end
            end
            chk("in_ready_load", 64'(in_ready), 1);
            in_valid = 1'b1;
            in_xi    = vec[i];
            in_last  = !trunc_mode && (i == n - 1);
            @(posedge clk); #1;
            chk("mv_valid", 64'(xi_mv_valid), 1);
            chk("xi_mv", xi_mv, m_mv(vec[i]));
            chk("mv_oor", 64'(mv_oor), 64'(m_oor(vec[i])));
            chk("trunc_err", 64'(trunc_err), 64'(trunc_mode && i == DEPTH - 1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("xmax", xmax, exp_max);
        chk("xmax_valid", 64'(xmax_valid), 1);
        chk("in_ready_closed", 64'(in_ready), 0);
    endtask

    // Consume up to stop differences; mode 0 ready=1, 1 pattern 1,0,0,1, 2 random.
    task automatic drain(input int n, input int exp_lat, input int mode, input int stop);
        int cyc, idx, first;
        bit hs;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        cyc = 0; idx = 0; first = -1;
        while (idx < stop && cyc < 200) begin
            case (mode)
                0:       sub_ready = 1'b1;
                1:       sub_ready = pat[cyc % 4];
                default: sub_ready = $urandom_range(0, 1);
            endcase
            if (sub_valid) begin
                if (first < 0) first = cyc;
                chk("sub_xi", sub_xi, exp_sub[idx]);
                chk("sub_last", 64'(sub_last), 64'(idx == n - 1));
                chk("xmax_valid_drain", 64'(xmax_valid), 1);
            end
            hs = sub_valid && sub_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) idx++;
        end
        chk("drain_count", idx, stop);
        chk("first_lat", first, exp_lat);
        if (mode == 0 && stop == n)
            chk("drain_cycles", cyc, n + exp_lat);
        if (stop == n) begin
            chk("in_ready_turn", 64'(in_ready), 1);
            chk("sub_valid_off", 64'(sub_valid), 0);
            chk("xmax_valid_off", 64'(xmax_valid), 0);
        end
        sub_ready = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_xi = '0; in_last = 1'b0; sub_ready = 1'b0;
        #12;
        check_zero("rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 64'(in_ready), 1);
        chk("sub_valid_after_rst", 64'(sub_valid), 0);

        // Basic vector
        vec[0] = 3; vec[1] = -5; vec[2] = 7; vec[3] = 0;
        load_vec(4, 0, 0);
        drain(4, 1, 0, 4);

        // All-negative vector
        vec[0] = -3; vec[1] = -9; vec[2] = -1;
        load_vec(3, 0, 0);
        drain(3, 1, 0, 3);

        // Saturation and out-of-range indices
        vec[0] = 100; vec[1] = -100;
        load_vec(2, 0, 0);
        drain(2, 1, 0, 2);

        // Truncation: 17th element must be refused
        for (int i = 0; i <= DEPTH; i++) vec[i] = DW'($urandom);
        load_vec(DEPTH, 1, 0);
        in_valid = 1'b1; in_xi = vec[DEPTH]; in_last = 1'b0;
        chk("in_ready_17th", 64'(in_ready), 0);
        @(posedge clk); #1;
        chk("mv_valid_17th", 64'(xi_mv_valid), 0);
        chk("trunc_err_pulse_end", 64'(trunc_err), 0);
        in_valid = 1'b0;
        drain(DEPTH, 0, 0, DEPTH);

        // Backpressure
        vec[0] = 10; vec[1] = -20; vec[2] = 30; vec[3] = -40;
        load_vec(4, 0, 0);
        drain(4, 1, 1, 4);

        // Reset mid-drain
        vec[0] = 12; vec[1] = -7; vec[2] = 44; vec[3] = 1;
        load_vec(4, 0, 0);
        drain(4, 1, 0, 2);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        vec[0] = 5;
        load_vec(1, 0, 0);
        drain(1, 1, 0, 1);

        // Randomized vectors
        for (int t = 0; t < 12; t++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) vec[i] = DW'($urandom);
            load_vec(n, 0, 1);
            drain(n, 1, 2, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
